// File: rtl/dma_channel_register_file_pkg.sv
// Shared configuration for the DMA register file: defaults, packed register
// layouts, register-map constants and byte-lane helpers.
package dmaRegConfigPkg;

    localparam int DEFAULT_CHANNELS     = 4;
    localparam int DEFAULT_ADDRESSWIDTH = 16;

    localparam logic [3:0] ADDR_STATUS   = 4'h8;
    localparam logic [3:0] ADDR_COMMAND  = 4'h8;
    localparam logic [3:0] ADDR_REQUEST  = 4'h9;
    localparam logic [3:0] ADDR_MASK     = 4'hA;
    localparam logic [3:0] ADDR_MODE     = 4'hB;
    localparam logic [3:0] ADDR_CLRPTR   = 4'hC;
    localparam logic [3:0] ADDR_MCLEAR   = 4'hD;
    localparam logic [3:0] ADDR_TEMP     = 4'hD;
    localparam logic [3:0] ADDR_CLRMASK  = 4'hE;
    localparam logic [3:0] ADDR_MASKALL  = 4'hF;

    typedef enum logic [1:0] {
        XFER_VERIFY  = 2'b00,
        XFER_WRITE   = 2'b01,
        XFER_READ    = 2'b10,
        XFER_ILLEGAL = 2'b11
    } xferType_e;

    typedef enum logic [1:0] {
        MODE_DEMAND  = 2'b00,
        MODE_SINGLE  = 2'b01,
        MODE_BLOCK   = 2'b10,
        MODE_CASCADE = 2'b11
    } modeSel_e;

    // Six-bit mode as written from dataIn[7:2].
    typedef struct packed {
        modeSel_e  modeSelect;
        logic      addressSelect;
        logic      autoInit;
        xferType_e xferType;
    } modeReg_t;

    typedef struct packed {
        logic dackSense;
        logic dreqSense;
        logic extendedWrite;
        logic rotatingPriority;
        logic compressedTiming;
        logic controllerDisable;
        logic addrHold;
        logic memToMem;
    } commandReg_t;

    typedef struct packed {
        logic [3:0] request;
        logic [3:0] tc;
    } statusReg_t;

    function automatic logic [31:0] laneWrite(input logic [31:0] value,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  data);
        logic [31:0] result;
        result = value;
        result[{lane, 3'b000} +: 8] = data;
        return result;
    endfunction

    function automatic logic [7:0] laneRead(input logic [31:0] value,
                                            input logic [1:0]  lane);
        return value[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dma_channel_register_file_counter.sv
// One channel's base/current address and word count with byte-lane CPU
// writes, per-transfer stepping, terminal-count detection and autoinit reload.
module dma_channel_counter
    import dmaRegConfigPkg::*;
#(
    parameter int ADDRESSWIDTH = DEFAULT_ADDRESSWIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    wrAddr_i,
    input  logic                    wrCount_i,
    input  logic [1:0]              bytePtr_i,
    input  logic [7:0]              data_i,
    input  logic                    step_i,
    input  logic                    decrement_i,
    input  logic                    autoInit_i,
    output logic [ADDRESSWIDTH-1:0] currAddr_o,
    output logic [ADDRESSWIDTH-1:0] currCount_o,
    output logic                    tc_o
);

    localparam logic [ADDRESSWIDTH-1:0] ONE = ADDRESSWIDTH'(1);

    logic [ADDRESSWIDTH-1:0] baseAddr_q, baseAddr_d;
    logic [ADDRESSWIDTH-1:0] currAddr_q, currAddr_d;
    logic [ADDRESSWIDTH-1:0] baseCount_q, baseCount_d;
    logic [ADDRESSWIDTH-1:0] currCount_q, currCount_d;

    function automatic logic [ADDRESSWIDTH-1:0] writeLane(input logic [ADDRESSWIDTH-1:0] value,
                                                          input logic [1:0] lane,
                                                          input logic [7:0] data);
        return ADDRESSWIDTH'(laneWrite(32'(value), lane, data));
    endfunction

    always_comb begin
        baseAddr_d  = baseAddr_q;
        currAddr_d  = currAddr_q;
        baseCount_d = baseCount_q;
        currCount_d = currCount_q;
        // TC is judged on the count before any same-cycle CPU write.
        tc_o        = step_i && (currCount_q == '0);

        if (step_i) begin
            if (tc_o && autoInit_i) begin
                currAddr_d  = baseAddr_q;
                currCount_d = baseCount_q;
            end else begin
                currAddr_d  = decrement_i ? currAddr_q - ONE : currAddr_q + ONE;
                currCount_d = currCount_q - ONE;
            end
        end

        // A CPU write overrides the step result for the register it targets.
        if (wrAddr_i) begin
            baseAddr_d = writeLane(baseAddr_q, bytePtr_i, data_i);
            currAddr_d = writeLane(currAddr_q, bytePtr_i, data_i);
        end
        if (wrCount_i) begin
            baseCount_d = writeLane(baseCount_q, bytePtr_i, data_i);
            currCount_d = writeLane(currCount_q, bytePtr_i, data_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            baseAddr_q  <= '0;
            currAddr_q  <= '0;
            baseCount_q <= '0;
            currCount_q <= '0;
        end else begin
            baseAddr_q  <= baseAddr_d;
            currAddr_q  <= currAddr_d;
            baseCount_q <= baseCount_d;
            currCount_q <= currCount_d;
        end
    end

    assign currAddr_o  = currAddr_q;
    assign currCount_o = currCount_q;

endmodule

// File: rtl/dma_channel_register_file.sv
// DMA register file top: CPU register decode, byte pointer, read mux and the
// shared command/mode/mask/request/status/temporary registers.
module dma_channel_register_file
    import dmaRegConfigPkg::*;
#(
    parameter int  CHANNELS     = DEFAULT_CHANNELS,
    parameter int  ADDRESSWIDTH = DEFAULT_ADDRESSWIDTH,
    localparam int BYTES        = ADDRESSWIDTH / 8
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      regWrite,
    input  logic                      regRead,
    input  logic [3:0]                regAddr,
    input  logic [7:0]                dataIn,
    output logic [7:0]                dataOut,
    input  logic                      xferStep,
    input  logic [1:0]                xferChannel,
    input  logic                      tempLoad,
    input  logic [7:0]                tempIn,
    output logic [ADDRESSWIDTH-1:0]   currentAddress,
    output logic [7:0]                commandReg,
    output logic [6*CHANNELS-1:0]     modeReg,
    output logic [CHANNELS-1:0]       maskReg,
    output logic [CHANNELS-1:0]       softRequest,
    output logic                      tcPulse
);

    logic        wrEn, rdEn, chanAccess, statusRead, masterClear, stepValid;
    logic [1:0]  regChan;

    logic [CHANNELS-1:0]     stepCh, wrAddrCh, wrCountCh, tcStep;
    logic [ADDRESSWIDTH-1:0] chAddr  [CHANNELS];
    logic [ADDRESSWIDTH-1:0] chCount [CHANNELS];

    commandReg_t         command_q, command_d;
    modeReg_t            mode_q [CHANNELS];
    modeReg_t            mode_d [CHANNELS];
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic [CHANNELS-1:0] request_q, request_d;
    logic [CHANNELS-1:0] tc_q, tc_d;
    logic [7:0]          temp_q, temp_d;
    logic [7:0]          dataOut_q, dataOut_d;
    logic                tcPulse_q, tcPulse_d;
    logic [1:0]          ptr_q, ptr_d;

    // A simultaneous read and write is treated as a write only.
    always_comb begin
        wrEn        = regWrite;
        rdEn        = regRead && !regWrite;
        regChan     = regAddr[2:1];
        chanAccess  = (wrEn || rdEn) && !regAddr[3];
        statusRead  = rdEn && (regAddr == ADDR_STATUS);
        masterClear = wrEn && (regAddr == ADDR_MCLEAR);
        stepValid   = xferStep && (int'(xferChannel) < CHANNELS);
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : gChan
        assign stepCh[i]    = stepValid && (xferChannel == 2'(i));
        assign wrAddrCh[i]  = wrEn && !regAddr[3] && (regChan == 2'(i)) && !regAddr[0];
        assign wrCountCh[i] = wrEn && !regAddr[3] && (regChan == 2'(i)) && regAddr[0];
        assign modeReg[6*i +: 6] = mode_q[i];

        dma_channel_counter #(
            .ADDRESSWIDTH(ADDRESSWIDTH)
        ) u_counter (
            .clk_i       (CLK),
            .rst_i       (RESET),
            .clear_i     (masterClear),
            .wrAddr_i    (wrAddrCh[i]),
            .wrCount_i   (wrCountCh[i]),
            .bytePtr_i   (ptr_q),
            .data_i      (dataIn),
            .step_i      (stepCh[i]),
            .decrement_i (mode_q[i].addressSelect),
            .autoInit_i  (mode_q[i].autoInit),
            .currAddr_o  (chAddr[i]),
            .currCount_o (chCount[i]),
            .tc_o        (tcStep[i])
        );
    end

    always_comb begin
        currentAddress = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (xferChannel == 2'(i)) currentAddress = chAddr[i];
        end
    end

    always_comb begin
        logic [ADDRESSWIDTH-1:0] sel;
        statusReg_t              status;

        command_d = command_q;
        mode_d    = mode_q;
        mask_d    = mask_q;
        request_d = request_q;
        temp_d    = temp_q;
        dataOut_d = dataOut_q;
        ptr_d     = ptr_q;
        sel       = '0;
        tcPulse_d = |tcStep;
        // A status read clears old TC bits but never swallows a fresh one.
        tc_d      = (statusRead ? '0 : tc_q) | tcStep;

        for (int i = 0; i < CHANNELS; i++) begin
            if (tcStep[i]) begin
                request_d[i] = 1'b0;
                if (!mode_q[i].autoInit) mask_d[i] = 1'b1;
            end
        end

        if (tempLoad) temp_d = tempIn;

        if (chanAccess) ptr_d = (ptr_q == 2'(BYTES - 1)) ? 2'd0 : ptr_q + 2'd1;

        if (wrEn) begin
            case (regAddr)
                ADDR_COMMAND: command_d = commandReg_t'(dataIn);
                ADDR_REQUEST: begin
                    for (int i = 0; i < CHANNELS; i++)
                        if (dataIn[1:0] == 2'(i)) request_d[i] = dataIn[2];
                end
                ADDR_MASK: begin
                    for (int i = 0; i < CHANNELS; i++)
                        if (dataIn[1:0] == 2'(i)) mask_d[i] = dataIn[2];
                end
                ADDR_MODE: begin
                    for (int i = 0; i < CHANNELS; i++)
                        if (dataIn[1:0] == 2'(i)) mode_d[i] = modeReg_t'(dataIn[7:2]);
                end
                ADDR_CLRPTR:  ptr_d  = 2'd0;
                ADDR_CLRMASK: mask_d = '0;
                ADDR_MASKALL: mask_d = dataIn[CHANNELS-1:0];
                default: ;
            endcase
        end

        status.request = 4'(request_q);
        status.tc      = 4'(tc_q);

        if (rdEn) begin
            dataOut_d = 8'h00;
            if (!regAddr[3]) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (regChan == 2'(i)) begin
                        sel       = regAddr[0] ? chCount[i] : chAddr[i];
                        dataOut_d = laneRead(32'(sel), ptr_q);
                    end
                end
            end else if (regAddr == ADDR_STATUS) begin
                dataOut_d = status;
            end else if (regAddr == ADDR_TEMP) begin
                dataOut_d = temp_q;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || masterClear) begin
            command_q <= '0;
            for (int i = 0; i < CHANNELS; i++) mode_q[i] <= '0;
            mask_q    <= '1;
            request_q <= '0;
            tc_q      <= '0;
            temp_q    <= '0;
            dataOut_q <= '0;
            tcPulse_q <= 1'b0;
            ptr_q     <= '0;
        end else begin
            command_q <= command_d;
            mode_q    <= mode_d;
            mask_q    <= mask_d;
            request_q <= request_d;
            tc_q      <= tc_d;
            temp_q    <= temp_d;
            dataOut_q <= dataOut_d;
            tcPulse_q <= tcPulse_d;
            ptr_q     <= ptr_d;
        end
    end

    assign commandReg  = command_q;
    assign maskReg     = mask_q;
    assign softRequest = request_q;
    assign tcPulse     = tcPulse_q;
    assign dataOut     = dataOut_q;

endmodule

// File: tb/tb_dma_channel_register_file.sv
// Scoreboard bench for the DMA register file: reads and steps queue their
// expected dataOut / tcPulse, a monitor pops and compares one cycle later.
module tb_dma_channel_register_file;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        regWrite = 1'b0;
    logic        regRead = 1'b0;
    logic [3:0]  regAddr = 4'h0;
    logic [7:0]  dataIn = 8'h00;
    logic        xferStep = 1'b0;
    logic [1:0]  xferChannel = 2'd0;
    logic        tempLoad = 1'b0;
    logic [7:0]  tempIn = 8'h00;

    logic [7:0]  dataOut, dataOut24;
    logic [15:0] currentAddress;
    logic [23:0] currentAddress24;
    logic [7:0]  commandReg, commandReg24;
    logic [23:0] modeReg, modeReg24;
    logic [3:0]  maskReg, maskReg24, softRequest, softRequest24;
    logic        tcPulse, tcPulse24;

    dma_channel_register_file #(.CHANNELS(4), .ADDRESSWIDTH(16)) dut (
        .CLK(CLK), .RESET(RESET), .regWrite(regWrite), .regRead(regRead),
        .regAddr(regAddr), .dataIn(dataIn), .dataOut(dataOut),
        .xferStep(xferStep), .xferChannel(xferChannel), .tempLoad(tempLoad),
        .tempIn(tempIn), .currentAddress(currentAddress), .commandReg(commandReg),
        .modeReg(modeReg), .maskReg(maskReg), .softRequest(softRequest),
        .tcPulse(tcPulse)
    );

    dma_channel_register_file #(.CHANNELS(4), .ADDRESSWIDTH(24)) dut24 (
        .CLK(CLK), .RESET(RESET), .regWrite(regWrite), .regRead(regRead),
        .regAddr(regAddr), .dataIn(dataIn), .dataOut(dataOut24),
        .xferStep(xferStep), .xferChannel(xferChannel), .tempLoad(tempLoad),
        .tempIn(tempIn), .currentAddress(currentAddress24), .commandReg(commandReg24),
        .modeReg(modeReg24), .maskReg(maskReg24), .softRequest(softRequest24),
        .tcPulse(tcPulse24)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] e16;
        logic [7:0] e24;
        bit         chk24;
    } rdExp_t;

    rdExp_t rdQ[$];
    bit     tcQ[$];
    int     nCompared = 0;
    int     nMismatched = 0;
    bit     rdFlag, stepFlag, rstFlag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: dataOut is checked after each read edge, tcPulse after every edge.
    initial begin : monitor
        rdExp_t e;
        bit     expTc;
        forever begin
            @(posedge CLK);
            rdFlag   = regRead && !regWrite;
            stepFlag = xferStep;
            rstFlag  = RESET;
            #1;
            if (rdFlag) begin
                if (rdQ.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("FAIL rd_queue: read seen with no expected value queued");
                end else begin
                    e = rdQ.pop_front();
                    chk("dataOut", 32'(dataOut), 32'(e.e16));
                    if (e.chk24) chk("dataOut24", 32'(dataOut24), 32'(e.e24));
                end
            end
            if (stepFlag) begin
                if (tcQ.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("FAIL tc_queue: step seen with no expected value queued");
                end else begin
                    expTc = tcQ.pop_front();
                    chk("tcPulse", 32'(tcPulse), 32'(expTc));
                end
            end else if (!rstFlag) begin
                chk("tcPulse_idle", 32'(tcPulse), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        regWrite = 1'b1; regAddr = a; dataIn = d;
        @(negedge CLK);
        regWrite = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] e);
        rdQ.push_back('{e, 8'h00, 1'b0});
        regRead = 1'b1; regAddr = a;
        @(negedge CLK);
        regRead = 1'b0;
    endtask

    task automatic rd2(input logic [3:0] a, input logic [7:0] e16, input logic [7:0] e24);
        rdQ.push_back('{e16, e24, 1'b1});
        regRead = 1'b1; regAddr = a;
        @(negedge CLK);
        regRead = 1'b0;
    endtask

    task automatic step(input logic [1:0] ch, input bit expTc);
        tcQ.push_back(expTc);
        xferStep = 1'b1; xferChannel = ch;
        @(negedge CLK);
        xferStep = 1'b0;
    endtask

    task automatic chkAddr(input logic [1:0] ch, input logic [15:0] e);
        xferChannel = ch;
        #1;
        chk($sformatf("currentAddress_ch%0d", ch), 32'(currentAddress), 32'(e));
    endtask

    initial begin : stimulus
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        chk("reset_dataOut", 32'(dataOut), 32'h00);
        chk("reset_mask", 32'(maskReg), 32'hF);
        chk("reset_request", 32'(softRequest), 32'h0);
        chk("reset_command", 32'(commandReg), 32'h00);
        chk("reset_mode", 32'(modeReg), 32'h0);
        chkAddr(2'd0, 16'h0000);

        rd(4'h8, 8'h00);
        wr(4'hB, 8'h00);
        rd(4'hB, 8'h00);
        chk("mask_after_reset_reads", 32'(maskReg), 32'hF);

        // Two-byte address write through the byte pointer.
        wr(4'hC, 8'h00);
        wr(4'h2, 8'h34);
        wr(4'h2, 8'h12);
        wr(4'hC, 8'h00);
        rd(4'h2, 8'h34);
        rd(4'h2, 8'h12);
        chkAddr(2'd1, 16'h1234);

        // Ch1 autoinit, count 0: one step is TC and reloads the base 0x1234.
        wr(4'hB, 8'h11);
        step(2'd1, 1'b1);
        chkAddr(2'd1, 16'h1234);
        rd(4'h8, 8'h02);
        rd(4'h8, 8'h00);

        // Ch0 count 2, no autoinit: TC on the third step.
        wr(4'hC, 8'h00);
        wr(4'h1, 8'h02);
        wr(4'h1, 8'h00);
        wr(4'hA, 8'h00);
        chk("mask_ch0_cleared", 32'(maskReg), 32'hE);
        step(2'd0, 1'b0);
        step(2'd0, 1'b0);
        step(2'd0, 1'b1);
        chk("mask_ch0_set_by_tc", 32'(maskReg), 32'hF);
        chkAddr(2'd0, 16'h0003);
        rd(4'h1, 8'hFF);
        rd(4'h1, 8'hFF);
        rd(4'h8, 8'h01);
        rd(4'h8, 8'h00);

        // Ch2 autoinit at 0x0100, count 0.
        wr(4'hC, 8'h00);
        wr(4'h4, 8'h00);
        wr(4'h4, 8'h01);
        wr(4'hB, 8'h12);
        wr(4'hA, 8'h02);
        step(2'd2, 1'b1);
        chkAddr(2'd2, 16'h0100);
        chk("mask_autoinit_unchanged", 32'(maskReg), 32'hB);
        rd(4'h8, 8'h04);

        // Ch3 decrement from 0, soft request cleared by TC.
        wr(4'hB, 8'h23);
        wr(4'hA, 8'h03);
        chk("mask_ch3_cleared", 32'(maskReg), 32'h3);
        wr(4'h9, 8'h07);
        chk("softRequest_set", 32'(softRequest), 32'h8);
        rd(4'h8, 8'h80);
        step(2'd3, 1'b1);
        chk("softRequest_cleared_by_tc", 32'(softRequest), 32'h0);
        chk("mask_ch3_set_by_tc", 32'(maskReg), 32'hB);
        chkAddr(2'd3, 16'hFFFF);
        rd(4'h8, 8'h08);

        // Status read in the same cycle as a TC step returns the old status.
        tcQ.push_back(1'b1);
        xferStep = 1'b1; xferChannel = 2'd2;
        rd(4'h8, 8'h00);
        xferStep = 1'b0;
        chkAddr(2'd2, 16'h0100);
        rd(4'h8, 8'h04);

        // CPU count write and step on ch0 together: address still steps.
        wr(4'hC, 8'h00);
        tcQ.push_back(1'b0);
        xferStep = 1'b1; xferChannel = 2'd0;
        wr(4'h1, 8'h05);
        xferStep = 1'b0;
        chkAddr(2'd0, 16'h0004);
        rd(4'h1, 8'hFF);
        rd(4'h1, 8'h05);

        // Read and write together: write only, pointer advances once.
        wr(4'hC, 8'h00);
        regRead = 1'b1;
        wr(4'h0, 8'hAA);
        regRead = 1'b0;
        chk("dataOut_held", 32'(dataOut), 32'h05);
        rd(4'h0, 8'h00);
        rd(4'h0, 8'hAA);

        tempIn = 8'h5A; tempLoad = 1'b1;
        @(negedge CLK);
        tempLoad = 1'b0;
        rd(4'hD, 8'h5A);
        wr(4'h8, 8'h44);
        chk("commandReg", 32'(commandReg), 32'h44);
        wr(4'hE, 8'h00);
        chk("mask_clear_all", 32'(maskReg), 32'h0);
        wr(4'hF, 8'h05);
        chk("mask_write_all", 32'(maskReg), 32'h5);
        chk("modeReg_packed", 32'(modeReg), 32'h204100);

        // Master clear in the middle of a two-byte write.
        wr(4'hC, 8'h00);
        wr(4'h0, 8'h77);
        wr(4'hD, 8'h00);
        chk("mclr_mask", 32'(maskReg), 32'hF);
        chk("mclr_request", 32'(softRequest), 32'h0);
        chk("mclr_command", 32'(commandReg), 32'h00);
        chk("mclr_mode", 32'(modeReg), 32'h0);
        chk("mclr_dataOut", 32'(dataOut), 32'h00);
        for (int c = 0; c < 4; c++) chkAddr(2'(c), 16'h0000);
        wr(4'h0, 8'h11);
        chkAddr(2'd0, 16'h0011);
        rd(4'h8, 8'h00);
        rd(4'hD, 8'h00);

        // Three-byte write: 16-bit pointer wraps after two, 24-bit after three.
        wr(4'hC, 8'h00);
        wr(4'h0, 8'h11);
        wr(4'h0, 8'h22);
        wr(4'h0, 8'h33);
        rd2(4'h0, 8'h22, 8'h11);
        chkAddr(2'd0, 16'h2233);
        chk("currentAddress24_ch0", 32'(currentAddress24), 32'h332211);

        repeat (2) @(negedge CLK);
        chk("rdQ_drained", 32'(rdQ.size()), 32'd0);
        chk("tcQ_drained", 32'(tcQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
